// File: rtl/imem_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_bank_pkg
// Description : Shared state encodings and default geometry for imem_bank.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_bank_pkg;

    // Defaults matching the legacy single-port memory geometry
    localparam int c_ISIZE = 16;
    localparam int c_DSIZE = 16;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/imem_bank_wrmask.sv
`default_nettype none
// ============================================================================
// Module      : imem_bank_wrmask
// Description : Byte-lane merge of an existing word with new write data.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_bank_wrmask #(
    parameter int DW = 16
) (
    input  logic [DW-1:0]   i_old_word,
    input  logic [DW-1:0]   i_data,
    input  logic [DW/8-1:0] i_be,
    output logic [DW-1:0]   o_word
);

    for (genvar i = 0; i < DW / 8; i++) begin : g_byte
        assign o_word[8*i +: 8] = i_be[i] ? i_data[8*i +: 8] : i_old_word[8*i +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/imem_bank.sv
`default_nettype none
// ============================================================================
// Module      : imem_bank
// Description : Parametrised instruction/data memory with load channel,
//               byte-enable writes, optional output register and clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_bank
    import imem_bank_pkg::*;
#(
    parameter int AW       = c_ISIZE,
    parameter int DW       = c_DSIZE,
    parameter int DEPTH    = 1 << AW,
    parameter int RD_LAT   = 1,
    parameter int CLEAR_EN = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            wen,
    input  logic [DW/8-1:0] be,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   data_in,
    output logic [DW-1:0]   data_out,
    input  logic            ld_valid,
    input  logic [AW-1:0]   ld_addr,
    input  logic [DW-1:0]   ld_data,
    input  logic            ld_done,
    output logic            ready
);

    localparam int            c_IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   c_DEPTH = (AW + 1)'(DEPTH);
    localparam logic [c_IW-1:0] c_LAST = c_IW'(DEPTH - 1);

    state_e          r_state;
    logic [c_IW-1:0] r_clr_cnt;
    logic [AW-1:0]   r_addr;
    logic            r_ready;
    logic [DW-1:0]   r_mem [DEPTH];

    logic            w_rd_ok;
    logic            w_wr_ok;
    logic            w_ld_ok;
    logic [DW-1:0]   w_rd_word;
    logic [DW-1:0]   w_old_word;
    logic [DW-1:0]   w_merged;
    logic            w_we;
    logic [c_IW-1:0] w_widx;
    logic [DW-1:0]   w_wdata;

    // Addresses beyond DEPTH never touch the array: reads return 0, writes drop
    assign w_rd_ok    = {1'b0, r_addr}  < c_DEPTH;
    assign w_wr_ok    = {1'b0, addr}    < c_DEPTH;
    assign w_ld_ok    = {1'b0, ld_addr} < c_DEPTH;
    assign w_rd_word  = w_rd_ok ? r_mem[r_addr[c_IW-1:0]] : '0;
    assign w_old_word = w_wr_ok ? r_mem[addr[c_IW-1:0]]   : '0;

    imem_bank_wrmask #(
        .DW (DW)
    ) u_wrmask (
        .i_old_word (w_old_word),
        .i_data     (data_in),
        .i_be       (be),
        .o_word     (w_merged)
    );

    always_comb begin
        w_we    = 1'b0;
        w_widx  = '0;
        w_wdata = '0;
        case (r_state)
            ST_CLEAR: begin
                w_we   = 1'b1;
                w_widx = r_clr_cnt;
            end
            ST_LOAD: begin
                if (ld_valid && w_ld_ok) begin
                    w_we    = 1'b1;
                    w_widx  = ld_addr[c_IW-1:0];
                    w_wdata = ld_data;
                end
            end
            ST_RUN: begin
                if (wen && w_wr_ok && (|be)) begin
                    w_we    = 1'b1;
                    w_widx  = addr[c_IW-1:0];
                    w_wdata = w_merged;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we && !rst) begin
            r_mem[w_widx] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= (CLEAR_EN != 0) ? ST_CLEAR : ST_LOAD;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_cnt == c_LAST) begin
                        r_clr_cnt <= '0;
                        r_state   <= ST_LOAD;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (ld_done) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_LOAD;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
        end else if (!stall) begin
            r_addr <= addr;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DW-1:0] r_out;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_out <= '0;
            end else if (!stall) begin
                r_out <= w_rd_word;
            end
        end

        assign data_out = r_out;
    end else begin : g_lat1
        assign data_out = w_rd_word;
    end

    assign ready = r_ready;

endmodule
`default_nettype wire
